// File: rtl/bus_mem_responder.sv
// bus_mem_responder: memory-side target for the CPU control strobes.
// Holds a byte-wide RAM, answers reads after a programmable number of wait
// states, commits each write once per mem_wr assertion and keeps a sticky
// protocol-error flag.
// Optional build macro: MEM_WR_PROTECT_EN (write-protect addresses below
// PROT_LIMIT).
module bus_mem_responder #(
  parameter int          ADDR_W      = 13,
  parameter int          DATA_W      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [15:0] PROT_LIMIT  = 16'h0100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              bus_enable,
  input  logic              halt,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_HOLD,
    S_WR_WAIT,
    S_WR_HOLD
  } state_t;

  localparam logic [2:0] WAIT_CNT_INIT = 3'(WAIT_STATES);

  state_t            state;
  state_t            state_nxt;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] lat_addr;
  logic [2:0]        wait_cnt;

  logic              rd_q;
  logic              wr_q;
  logic              rd_rise;
  logic              wr_rise;

  // FSM control strobes towards the datapath
  logic              lat_en;
  logic              cnt_dec;
  logic              rd_fire;
  logic              wr_fire;
  logic              err_set;
  logic              valid_clr;
  logic              wr_blocked;

`ifdef MEM_WR_PROTECT_EN
  assign wr_blocked = (32'(lat_addr) < 32'(PROT_LIMIT));
`else
  logic unused_prot;
  assign unused_prot = ^PROT_LIMIT;
  assign wr_blocked  = 1'b0;
`endif

  assign rd_rise = mem_rd & ~rd_q;
  assign wr_rise = mem_wr & ~wr_q;

  // Previous-cycle strobe levels for edge detection. Left running through
  // reset so a strobe held across reset is not mistaken for a new start.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    rd_q <= mem_rd;
    wr_q <= mem_wr;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and datapath control
  always_comb begin
    // NOTE: every output of this block is given a default first; a path that
    // leaves one unassigned would infer a latch.
    state_nxt = state;
    lat_en    = 1'b0;
    cnt_dec   = 1'b0;
    rd_fire   = 1'b0;
    wr_fire   = 1'b0;
    err_set   = 1'b0;
    valid_clr = 1'b0;
    busy      = (state == S_RD_WAIT) || (state == S_WR_WAIT);

    unique case (state)
      S_IDLE: begin
        if (mem_rd && mem_wr) begin
          // Both strobes at once: flag it and start nothing.
          err_set = 1'b1;
        end else if (rd_rise) begin
          if (!halt) begin
            lat_en    = 1'b1;
            state_nxt = S_RD_WAIT;
          end
        end else if (wr_rise) begin
          if (!bus_enable) begin
            err_set = 1'b1;
          end else if (!halt) begin
            lat_en    = 1'b1;
            state_nxt = S_WR_WAIT;
          end
        end
      end

      S_RD_WAIT: begin
        if (!mem_rd) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == '0) begin
          rd_fire   = 1'b1;
          state_nxt = S_RD_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      S_RD_HOLD: begin
        if (!mem_rd) begin
          valid_clr = 1'b1;
          state_nxt = S_IDLE;
        end else if (!halt && (addr != lat_addr)) begin
          // Consecutive fetch with mem_rd held: relatch and wait again.
          lat_en    = 1'b1;
          valid_clr = 1'b1;
          state_nxt = S_RD_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (!mem_wr) begin
          state_nxt = S_IDLE;
        end else if (wait_cnt == '0) begin
          if (bus_enable && !wr_blocked) begin
            wr_fire = 1'b1;
          end else begin
            err_set = 1'b1;
          end
          state_nxt = S_WR_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      S_WR_HOLD: begin
        if (!mem_wr) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Address latch, wait counter, read data, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr   <= '0;
      wait_cnt   <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      wr_done    <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      wr_done <= wr_fire;

      if (lat_en) begin
        lat_addr <= addr;
        wait_cnt <= WAIT_CNT_INIT;
      end else if (cnt_dec) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (rd_fire) begin
        data_out   <= mem[lat_addr];
        data_valid <= 1'b1;
      end else if (valid_clr) begin
        data_valid <= 1'b0;
      end

      if (err_set) begin
        proto_err <= 1'b1;
      end
    end
  end

  // RAM write port; a reset in the commit cycle suppresses the write
  // NOTE: the RAM array has no reset; its contents survive rst and clearing
  // it would prevent mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) begin
      mem[lat_addr] <= data_in;
    end
  end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder. Inputs change and outputs are
// sampled on the falling clock edge. Expected values come from a byte-array
// model of memory and the timing rule "entry on the strobe's first edge,
// data valid / commit WAIT_STATES+1 edges later".
module tb_bus_mem_responder;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int WS = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] addr = '0;
  logic          mem_rd = 1'b0;
  logic          mem_wr = 1'b0;
  logic          bus_enable = 1'b0;
  logic          halt = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          wr_done;
  logic          busy;
  logic          proto_err;

  int total = 0;
  int bad   = 0;
  logic          exp_err = 1'b0;
  logic [DW-1:0] model_mem [int];

  bus_mem_responder #(
    .ADDR_W(AW), .DATA_W(DW), .WAIT_STATES(WS)
  ) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .bus_enable(bus_enable), .halt(halt), .data_in(data_in),
    .data_out(data_out), .data_valid(data_valid), .wr_done(wr_done),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
    exp_err = 1'b0;
  endtask

  // Drives one write: mem_wr held for 'hold' cycles, then released.
  task automatic run_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic be, input int hold, input logic halt_start,
                           input int halt_at, output int pulses,
                           output int pulse_at, output int busy_n);
    addr = a; data_in = d; bus_enable = be; halt = halt_start; mem_wr = 1'b1;
    pulses = 0; pulse_at = 0; busy_n = 0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (wr_done) begin
        pulses++;
        if (pulse_at == 0) pulse_at = c;
      end
      if (busy) busy_n++;
      if (halt_at != 0 && c == halt_at) halt = 1'b1;
    end
    mem_wr = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (wr_done) pulses++;
    end
    bus_enable = 1'b0;
    halt = 1'b0;
  endtask

  // Drives one read: mem_rd held for 'hold' cycles, then released.
  task automatic run_read(input logic [AW-1:0] a, input int hold,
                          output int first_valid, output logic [DW-1:0] dv,
                          output int valid_n, output logic valid_after,
                          output logic [DW-1:0] dout_after);
    addr = a; mem_rd = 1'b1;
    first_valid = 0; valid_n = 0; dv = '0;
    for (int c = 1; c <= hold; c++) begin
      tick();
      if (data_valid) begin
        valid_n++;
        if (first_valid == 0) begin
          first_valid = c;
          dv = data_out;
        end
      end
    end
    mem_rd = 1'b0;
    tick();
    valid_after = data_valid;
    dout_after  = data_out;
  endtask

  task automatic test_reset();
    apply_reset(2);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data_out: got %0h want 0", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL rst_data_valid: got %b want 0", data_valid); end
    total++; if (wr_done !== 1'b0) begin bad++; $display("FAIL rst_wr_done: got %b want 0", wr_done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL rst_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_write_read();
    int p, pa, bn, fv, vn;
    logic [DW-1:0] dv, da;
    logic va;
    run_write(13'h0200, 8'hA5, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    model_mem[32'h0200] = 8'hA5;
    total++; if (p !== 1) begin bad++; $display("FAIL wr_pulses: got %0d want 1", p); end
    total++; if (pa !== WS + 2) begin bad++; $display("FAIL wr_pulse_cycle: got %0d want %0d", pa, WS + 2); end
    total++; if (bn !== WS + 1) begin bad++; $display("FAIL wr_busy_cycles: got %0d want %0d", bn, WS + 1); end
    run_read(13'h0200, WS + 4, fv, dv, vn, va, da);
    total++; if (fv !== WS + 2) begin bad++; $display("FAIL rd_latency: got %0d want %0d", fv, WS + 2); end
    total++; if (dv !== 8'hA5) begin bad++; $display("FAIL rd_data: got %0h want a5", dv); end
    total++; if (vn !== 3) begin bad++; $display("FAIL rd_valid_cycles: got %0d want 3", vn); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL rd_valid_drop: got %b want 0", va); end
    total++; if (da !== 8'hA5) begin bad++; $display("FAIL rd_data_kept: got %0h want a5", da); end
  endtask

  task automatic test_back_to_back();
    int p, pa, bn;
    run_write(13'h0300, 8'h5A, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    run_write(13'h0301, 8'h3C, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    model_mem[32'h0300] = 8'h5A;
    model_mem[32'h0301] = 8'h3C;
    addr = 13'h0300; mem_rd = 1'b1;
    for (int c = 1; c <= WS + 2; c++) begin
      tick();
      total++; if (data_valid !== (c == WS + 2)) begin bad++; $display("FAIL b2b_first_valid c%0d: got %b want %b", c, data_valid, c == WS + 2); end
    end
    total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL b2b_first_data: got %0h want 5a", data_out); end
    addr = 13'h0301;
    for (int c = 1; c <= WS + 2; c++) begin
      tick();
      total++; if (data_valid !== (c == WS + 2)) begin bad++; $display("FAIL b2b_second_valid c%0d: got %b want %b", c, data_valid, c == WS + 2); end
    end
    total++; if (data_out !== 8'h3C) begin bad++; $display("FAIL b2b_second_data: got %0h want 3c", data_out); end
    mem_rd = 1'b0;
    tick();
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b want 0", data_valid); end
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL b2b_proto_err: got %b want 0", proto_err); end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8];
    logic [DW-1:0] d, dv, da;
    logic va;
    int p, pa, bn, fv, vn, hold, k;
    logic commit;
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'($urandom_range(32'h1FFF, 32'h0400));
      d = DW'($urandom);
      run_write(pool[i], d, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
      model_mem[int'(pool[i])] = d;
    end
    for (int i = 0; i < 20; i++) begin
      k = $urandom_range(7, 0);
      d = DW'($urandom);
      hold = $urandom_range(WS + 4, WS);
      commit = (hold >= WS + 2);
      run_write(pool[k], d, 1'b1, hold, 1'b0, 0, p, pa, bn);
      if (commit) model_mem[int'(pool[k])] = d;
      total++; if (p !== (commit ? 1 : 0)) begin bad++; $display("FAIL rnd_wr_pulses it%0d hold%0d: got %0d want %0d", i, hold, p, commit ? 1 : 0); end
      total++; if (bn !== ((hold < WS + 1) ? hold : WS + 1)) begin bad++; $display("FAIL rnd_wr_busy it%0d: got %0d want %0d", i, bn, (hold < WS + 1) ? hold : WS + 1); end
      k = $urandom_range(7, 0);
      hold = $urandom_range(WS + 5, WS + 2);
      run_read(pool[k], hold, fv, dv, vn, va, da);
      total++; if (fv !== WS + 2) begin bad++; $display("FAIL rnd_rd_latency it%0d: got %0d want %0d", i, fv, WS + 2); end
      total++; if (dv !== model_mem[int'(pool[k])]) begin bad++; $display("FAIL rnd_rd_data it%0d addr %0h: got %0h want %0h", i, pool[k], dv, model_mem[int'(pool[k])]); end
      total++; if (vn !== hold - WS - 1) begin bad++; $display("FAIL rnd_rd_valid_cycles it%0d: got %0d want %0d", i, vn, hold - WS - 1); end
    end
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL rnd_proto_err: got %b want %b", proto_err, exp_err); end
  endtask

  task automatic test_halt();
    int p, pa, bn, fv, vn;
    logic [DW-1:0] dv, da;
    logic va;
    run_write(13'h0220, 8'h11, 1'b1, WS + 3, 1'b1, 0, p, pa, bn);
    total++; if (p !== 0) begin bad++; $display("FAIL halt_wr_pulses: got %0d want 0", p); end
    total++; if (bn !== 0) begin bad++; $display("FAIL halt_busy: got %0d want 0", bn); end
    run_write(13'h0220, 8'h11, 1'b1, WS + 3, 1'b0, 0, p, pa, bn);
    model_mem[32'h0220] = 8'h11;
    total++; if (p !== 1) begin bad++; $display("FAIL unhalt_wr_pulses: got %0d want 1", p); end
    // Halt raised after the write has started: it still completes.
    run_write(13'h0222, 8'h22, 1'b1, WS + 3, 1'b0, 1, p, pa, bn);
    model_mem[32'h0222] = 8'h22;
    total++; if (p !== 1) begin bad++; $display("FAIL halt_inflight_pulses: got %0d want 1", p); end
    halt = 1'b1;
    run_read(13'h0220, WS + 3, fv, dv, vn, va, da);
    halt = 1'b0;
    total++; if (vn !== 0) begin bad++; $display("FAIL halt_rd_valid: got %0d want 0", vn); end
    run_read(13'h0220, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== model_mem[32'h0220]) begin bad++; $display("FAIL halt_rd_data: got %0h want %0h", dv, model_mem[32'h0220]); end
    run_read(13'h0222, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== model_mem[32'h0222]) begin bad++; $display("FAIL inflight_rd_data: got %0h want %0h", dv, model_mem[32'h0222]); end
  endtask

  task automatic test_abort_reset();
    int p, pa, bn, fv, vn, pulses;
    logic [DW-1:0] dv, da;
    logic va;
    run_read(13'h0300, 2, fv, dv, vn, va, da);
    total++; if (vn !== 0) begin bad++; $display("FAIL abort_rd_valid: got %0d want 0", vn); end
    total++; if (va !== 1'b0) begin bad++; $display("FAIL abort_rd_valid_after: got %b want 0", va); end
    run_write(13'h0210, 8'h77, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    model_mem[32'h0210] = 8'h77;
    addr = 13'h0210; data_in = 8'h99; bus_enable = 1'b1; mem_wr = 1'b1;
    pulses = 0;
    repeat (2) begin tick(); if (wr_done) pulses++; end
    rst = 1'b1;
    repeat (WS + 1) begin tick(); if (wr_done) pulses++; end
    rst = 1'b0;
    exp_err = 1'b0;
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL midrst_data_out: got %0h want 0", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    repeat (WS + 3) begin tick(); if (wr_done) pulses++; end
    mem_wr = 1'b0; bus_enable = 1'b0;
    tick();
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_wr_pulses: got %0d want 0", pulses); end
    run_read(13'h0210, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== 8'h77) begin bad++; $display("FAIL midrst_old_value: got %0h want 77", dv); end
  endtask

  task automatic test_illegal();
    int p, pa, bn, fv, vn, pulses, busy_n;
    logic [DW-1:0] dv, da;
    logic va;
    run_write(13'h0230, 8'h44, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    model_mem[32'h0230] = 8'h44;
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL ill_err_before: got %b want 0", proto_err); end
    addr = 13'h0230; data_in = 8'hEE; bus_enable = 1'b1; mem_rd = 1'b1; mem_wr = 1'b1;
    pulses = 0; busy_n = 0;
    repeat (WS + 3) begin tick(); if (wr_done) pulses++; if (busy) busy_n++; end
    mem_rd = 1'b0; mem_wr = 1'b0; bus_enable = 1'b0;
    tick();
    exp_err = 1'b1;
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL ill_both_err: got %b want %b", proto_err, exp_err); end
    total++; if (pulses !== 0 || busy_n !== 0) begin bad++; $display("FAIL ill_both_access: got pulses=%0d busy=%0d want 0 0", pulses, busy_n); end
    run_read(13'h0230, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== 8'h44) begin bad++; $display("FAIL ill_both_ram: got %0h want 44", dv); end

    apply_reset(2);
    total++; if (proto_err !== 1'b0) begin bad++; $display("FAIL ill_err_cleared: got %b want 0", proto_err); end
    run_write(13'h0240, 8'h55, 1'b0, WS + 3, 1'b0, 0, p, pa, bn);
    exp_err = 1'b1;
    total++; if (p !== 0) begin bad++; $display("FAIL ill_nobe_pulses: got %0d want 0", p); end
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL ill_nobe_err: got %b want %b", proto_err, exp_err); end

    // bus_enable lost before the commit cycle
    apply_reset(2);
    run_write(13'h0250, 8'h66, 1'b1, WS + 2, 1'b0, 0, p, pa, bn);
    model_mem[32'h0250] = 8'h66;
    addr = 13'h0250; data_in = 8'hBB; bus_enable = 1'b1; mem_wr = 1'b1;
    pulses = 0; busy_n = 0;
    tick(); if (busy) busy_n++;
    bus_enable = 1'b0;
    repeat (WS + 2) begin tick(); if (wr_done) pulses++; if (busy) busy_n++; end
    mem_wr = 1'b0;
    tick();
    exp_err = 1'b1;
    total++; if (pulses !== 0) begin bad++; $display("FAIL ill_belost_pulses: got %0d want 0", pulses); end
    total++; if (busy_n !== WS + 1) begin bad++; $display("FAIL ill_belost_busy: got %0d want %0d", busy_n, WS + 1); end
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL ill_belost_err: got %b want %b", proto_err, exp_err); end
    run_read(13'h0250, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== 8'h66) begin bad++; $display("FAIL ill_belost_ram: got %0h want 66", dv); end
  endtask

  task automatic test_protect();
    int p, pa, bn, fv, vn;
    logic [DW-1:0] dv, da;
    logic va;
    apply_reset(2);
`ifdef MEM_WR_PROTECT_EN
    run_write(13'h0010, 8'hFF, 1'b1, WS + 3, 1'b0, 0, p, pa, bn);
    exp_err = 1'b1;
    total++; if (p !== 0) begin bad++; $display("FAIL prot_low_pulses: got %0d want 0", p); end
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL prot_low_err: got %b want %b", proto_err, exp_err); end
    run_write(13'h00FF, 8'h12, 1'b1, WS + 3, 1'b0, 0, p, pa, bn);
    total++; if (p !== 0) begin bad++; $display("FAIL prot_edge_pulses: got %0d want 0", p); end
`else
    run_write(13'h0010, 8'hFF, 1'b1, WS + 3, 1'b0, 0, p, pa, bn);
    model_mem[32'h0010] = 8'hFF;
    total++; if (p !== 1) begin bad++; $display("FAIL noprot_low_pulses: got %0d want 1", p); end
    total++; if (proto_err !== exp_err) begin bad++; $display("FAIL noprot_err: got %b want %b", proto_err, exp_err); end
    run_read(13'h0010, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== 8'hFF) begin bad++; $display("FAIL noprot_low_data: got %0h want ff", dv); end
`endif
    run_write(13'h0100, 8'hAB, 1'b1, WS + 3, 1'b0, 0, p, pa, bn);
    model_mem[32'h0100] = 8'hAB;
    total++; if (p !== 1) begin bad++; $display("FAIL prot_limit_pulses: got %0d want 1", p); end
    run_read(13'h0100, WS + 2, fv, dv, vn, va, da);
    total++; if (dv !== 8'hAB) begin bad++; $display("FAIL prot_limit_data: got %0h want ab", dv); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random();
    test_halt();
    test_abort_reset();
    test_illegal();
    test_protect();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
